// File: rtl/bios_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bios_mem_arbiter
// Shares the single-port, synchronous-read BIOS memory between instruction
// fetch (IF) and data loads (D). At most one requester is granted per cycle;
// read data comes back one cycle after the grant, tagged to its owner.
// D normally wins a collision, but after MAX_STREAK consecutive D grants with a
// fetch waiting, IF is granted once so fetch cannot starve (MAX_STREAK = 0
// disables this and gives D strict priority).
//
// Optional feature: define BIOS_ARB_PERF_EN to add two performance counters.
//
// Ports
//   clk               clock, all state on the rising edge
//   rst               synchronous, active-low reset (rst == 0 resets)
//   if_req_i          fetch read request, held with if_addr_i until granted
//   if_addr_i         fetch word address
//   if_flush_i        discard the fetch response returning this cycle
//   if_gnt_o          fetch granted this cycle (combinational)
//   if_rvalid_o       fetch data valid on if_rdata_o
//   if_rdata_o        fetch read data (mem_rdata_i)
//   d_req_i           data load request, held with d_addr_i until granted
//   d_addr_i          data word address
//   d_gnt_o           data granted this cycle (combinational)
//   d_rvalid_o        load data valid on d_rdata_o
//   d_rdata_o         load read data (mem_rdata_i)
//   stall_if_o        fetch is requesting but denied this cycle
//   mem_en_o          memory read enable
//   mem_addr_o        memory word address
//   mem_rdata_i       memory output, valid one cycle after mem_en_o
//   perf_if_stall_o   (BIOS_ARB_PERF_EN) cycles with stall_if_o high
//   perf_d_grant_o    (BIOS_ARB_PERF_EN) number of D grants
// -----------------------------------------------------------------------------
module bios_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int MAX_STREAK = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              stall_if_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i
`ifdef BIOS_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_if_stall_o,
  output logic [CNT_W-1:0]  perf_d_grant_o
`endif
);

  // A zero MAX_STREAK still needs a one-bit counter so the logic stays legal.
  localparam int STREAK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                ifGnt, dGnt, fairTurn;

  // Owner tag of the read issued last cycle, plus the count of D grants that
  // have overtaken a waiting fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Grant selection and next owner/streak. Everything stays idle while reset
  // is asserted so no read is launched during reset.
  always_comb begin
    ifGnt    = 1'b0;
    dGnt     = 1'b0;
    owner_d  = OWN_NONE;
    streak_d = '0;
    fairTurn = (MAX_STREAK != 0) && (streak_q == STREAK_MAX);
    if (rst) begin
      // D wins a collision unless fetch has waited out its full streak.
      if (d_req_i && !(if_req_i && fairTurn)) begin
        dGnt = 1'b1;
      end else if (if_req_i) begin
        ifGnt = 1'b1;
      end
      if (dGnt) begin
        owner_d = OWN_D;
      end else if (ifGnt) begin
        owner_d = OWN_IF;
      end
      // The streak only grows while fetch is actually being overtaken.
      if (dGnt && if_req_i) begin
        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
      end
    end
  end

  assign if_gnt_o    = ifGnt;
  assign d_gnt_o     = dGnt;
  assign stall_if_o  = rst & if_req_i & ~ifGnt;
  assign mem_en_o    = ifGnt | dGnt;
  assign mem_addr_o  = !rst ? '0 : (dGnt ? d_addr_i : if_addr_i);
  // A read in flight when reset arrives never produces a response.
  assign if_rvalid_o = rst && (owner_q == OWN_IF) && !if_flush_i;
  assign d_rvalid_o  = rst && (owner_q == OWN_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

`ifdef BIOS_ARB_PERF_EN
  logic [CNT_W-1:0] perf_if_stall_q, perf_d_grant_q;

  // Free-running event counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_if_stall_q <= '0;
      perf_d_grant_q  <= '0;
    end else begin
      if (stall_if_o) perf_if_stall_q <= perf_if_stall_q + 1'b1;
      if (dGnt)       perf_d_grant_q  <= perf_d_grant_q + 1'b1;
    end
  end

  assign perf_if_stall_o = perf_if_stall_q;
  assign perf_d_grant_o  = perf_d_grant_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_bios_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bios_mem_arbiter
// Self-checking bench for bios_mem_arbiter. Two instances share the stimulus:
// dut (MAX_STREAK = 4) is checked against a cycle model of the arbitration
// rules; strictDut (MAX_STREAK = 0) is checked against plain D priority.
// The bench also plays the BIOS memory: a random-content array read one cycle
// after mem_en_o.
// -----------------------------------------------------------------------------
module tb_bios_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, ifFlush, dReq;
  logic [11:0] ifAddr, dAddr;
  logic [31:0] memRdata = 32'h0;

  logic        ifGnt, ifRvalid, dGnt, dRvalid, stallIf, memEn;
  logic [31:0] ifRdata, dRdata;
  logic [11:0] memAddr;

  logic        sIfGnt, sIfRvalid, sDGnt, sDRvalid, sStall, sMemEn;
  logic [31:0] sIfRdata, sDRdata;
  logic [11:0] sMemAddr;

`ifdef BIOS_ARB_PERF_EN
  logic [31:0] perfStall, perfDGrant, sPerfStall, sPerfDGrant;
`endif

  logic [31:0] memArr [4096];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: who owns the response due this cycle, and how
  // many D grants in a row have overtaken a waiting fetch.
  int          streakM = 0;
  bit          pendIf  = 1'b0;
  bit          pendD   = 1'b0;
  logic [11:0] pendAddr = 12'h0;
  int          perfStallM = 0;
  int          perfDM     = 0;

  bios_mem_arbiter #(.ADDR_W(12), .MAX_STREAK(MAXS), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_flush_i(ifFlush),
    .if_gnt_o(ifGnt), .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata),
    .d_req_i(dReq), .d_addr_i(dAddr),
    .d_gnt_o(dGnt), .d_rvalid_o(dRvalid), .d_rdata_o(dRdata),
    .stall_if_o(stallIf), .mem_en_o(memEn), .mem_addr_o(memAddr),
    .mem_rdata_i(memRdata)
`ifdef BIOS_ARB_PERF_EN
    , .perf_if_stall_o(perfStall), .perf_d_grant_o(perfDGrant)
`endif
  );

  bios_mem_arbiter #(.ADDR_W(12), .MAX_STREAK(0), .CNT_W(32)) strictDut (
    .clk(clk), .rst(rst),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_flush_i(ifFlush),
    .if_gnt_o(sIfGnt), .if_rvalid_o(sIfRvalid), .if_rdata_o(sIfRdata),
    .d_req_i(dReq), .d_addr_i(dAddr),
    .d_gnt_o(sDGnt), .d_rvalid_o(sDRvalid), .d_rdata_o(sDRdata),
    .stall_if_o(sStall), .mem_en_o(sMemEn), .mem_addr_o(sMemAddr),
    .mem_rdata_i(memRdata)
`ifdef BIOS_ARB_PERF_EN
    , .perf_if_stall_o(sPerfStall), .perf_d_grant_o(sPerfDGrant)
`endif
  );

  // 100 MHz-style clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // BIOS memory behaviour: synchronous read of the main instance's address.
  always @(posedge clk) begin
    if (memEn) memRdata <= memArr[memAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, well away from the
  // rising edge that samples them.
  task automatic applyStimulus(input logic r, input logic iq, input logic [11:0] ia,
                               input logic fl, input logic dq, input logic [11:0] da);
    @(negedge clk);
    rst     = r;
    ifReq   = iq;
    ifAddr  = ia;
    ifFlush = fl;
    dReq    = dq;
    dAddr   = da;
  endtask

  // Compare every output against the model for the current cycle, then
  // advance the model across the coming rising edge.
  task automatic checkOutput(input string tag);
    logic        eIf, eD, eStall, eIfRv, eDRv;
    logic [11:0] eAddr;
    bit          fetchTurn;
    #2;
    fetchTurn = (MAXS > 0) && (streakM == MAXS);
    eIf    = rst && ifReq && (!dReq || fetchTurn);
    eD     = rst && dReq && !eIf;
    eStall = rst && ifReq && !eIf;
    eAddr  = !rst ? 12'h0 : (eD ? dAddr : ifAddr);
    eIfRv  = rst && pendIf && !ifFlush;
    eDRv   = rst && pendD;

    chk({tag, ":if_gnt"},    32'(ifGnt),    32'(eIf));
    chk({tag, ":d_gnt"},     32'(dGnt),     32'(eD));
    chk({tag, ":stall_if"},  32'(stallIf),  32'(eStall));
    chk({tag, ":mem_en"},    32'(memEn),    32'(eIf | eD));
    chk({tag, ":mem_addr"},  32'(memAddr),  32'(eAddr));
    chk({tag, ":if_rvalid"}, 32'(ifRvalid), 32'(eIfRv));
    chk({tag, ":d_rvalid"},  32'(dRvalid),  32'(eDRv));
    if (eIfRv) chk({tag, ":if_rdata"}, ifRdata, memArr[pendAddr]);
    if (eDRv)  chk({tag, ":d_rdata"},  dRdata,  memArr[pendAddr]);
    chk({tag, ":strict_d_gnt"},  32'(sDGnt),  32'(rst & dReq));
    chk({tag, ":strict_if_gnt"}, 32'(sIfGnt), 32'(rst & ifReq & ~dReq));
`ifdef BIOS_ARB_PERF_EN
    chk({tag, ":perf_if_stall"}, perfStall,  32'(perfStallM));
    chk({tag, ":perf_d_grant"},  perfDGrant, 32'(perfDM));
`endif

    if (!rst) begin
      streakM    = 0;
      pendIf     = 1'b0;
      pendD      = 1'b0;
      perfStallM = 0;
      perfDM     = 0;
    end else begin
      pendIf   = eIf;
      pendD    = eD;
      pendAddr = eAddr;
      if (eD && ifReq) streakM = (streakM >= MAXS) ? MAXS : streakM + 1;
      else             streakM = 0;
      if (eStall) perfStallM++;
      if (eD)     perfDM++;
    end
  endtask

  int contentionD [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    for (int i = 0; i < 4096; i++) memArr[i] = $urandom;
    memArr[12'h010] = 32'h0000_0013;

    rst = 1'b0; ifReq = 1'b0; ifAddr = 12'h0; ifFlush = 1'b0;
    dReq = 1'b0; dAddr = 12'h0;

    // Reset held three cycles with both requests up: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 12'h100, 1'b0, 1'b1, 12'h200);
      checkOutput("reset");
      chk("reset_mem_en", 32'(memEn), 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 12'h100, 1'b0, 1'b1, 12'h200);
    checkOutput("release");
    chk("release_d_first", 32'(dGnt), 32'h1);

    // IF alone: granted at once, data back next cycle.
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000);
    checkOutput("idle");
    applyStimulus(1'b1, 1'b1, 12'h010, 1'b0, 1'b0, 12'h000);
    checkOutput("if_only_req");
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000);
    checkOutput("if_only_resp");
    chk("if_only_rdata", ifRdata, 32'h0000_0013);

    // Contention: D,D,D,D,IF repeating.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 12'(12'h300 + i), 1'b0, 1'b1, 12'(12'h400 + i));
      checkOutput("contention");
      chk("contention_seq", 32'(dGnt), 32'(contentionD[i]));
    end

    // Flush: response of cycle N suppressed, new fetch granted at N+1 returns.
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000);
    checkOutput("idle");
    applyStimulus(1'b1, 1'b1, 12'h020, 1'b0, 1'b0, 12'h000);
    checkOutput("flush_n");
    applyStimulus(1'b1, 1'b1, 12'h040, 1'b1, 1'b0, 12'h000);
    checkOutput("flush_n1");
    chk("flush_n1_rvalid", 32'(ifRvalid), 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000);
    checkOutput("flush_n2");
    chk("flush_n2_rvalid", 32'(ifRvalid), 32'h1);

    // Reset arriving while a D read is in flight.
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h055);
    checkOutput("rst_mid_n");
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000);
    checkOutput("rst_mid_n1");
    chk("rst_mid_d_rvalid", 32'(dRvalid), 32'h0);
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000);
    checkOutput("rst_mid_n2");

    // Randomized traffic, biased toward collisions so the streak saturates.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(31) != 0),
                    ($urandom_range(3) != 0), 12'($urandom),
                    ($urandom_range(3) == 0),
                    ($urandom_range(3) != 0), 12'($urandom));
      checkOutput("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
